// File: rtl/clm_digit_serial_multiplier.sv
// Digit-serial code-based-masked GF(2^8) multiplier: DIGIT p1 bits per
// cycle with per-bit refresh, then one masked reduction cycle.
module clm_digit_serial_multiplier #(
   parameter  int D     = 2,
   parameter  int DIGIT = 1,
   localparam int N     = 8 + D,
   localparam int STEPS = N / DIGIT,
   localparam int RW    = (N + 1) * D,
   localparam int MW    = D * N,
   localparam int VW    = 7 + 2 * D,
   localparam int BW    = VW * 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  p1,
   input  logic [N-1:0]  p2,
   input  logic [RW-1:0] rand_vec,
   input  logic [MW-1:0] MC,
   input  logic [BW-1:0] B_ext,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out
);

   localparam int AW = 2 * N - 1;
   localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;

   if (N % DIGIT != 0) begin : g_bad_digit
      $error("DIGIT must divide N");
   end
   if (D < 1 || D > 8) begin : g_bad_d
      $error("D must be in 1..8");
   end

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      REDUCE,
      DONE
   } state_t;

   state_t        state;
   logic [N-1:0]  p1_q;
   logic [N-1:0]  p2_q;
   logic [RW-1:0] rnd_q;
   logic [AW-1:0] acc;
   logic [AW-1:0] acc_nxt;
   logic [KW-1:0] k;

   logic [N-2:0]  ov;
   logic [D-1:0]  q;
   logic [VW-1:0] v;
   logic [VW-1:0] col;
   logic [7:0]    red;
   logic [N-1:0]  res;

   // refresh vector: GF(2) product of one random vector with the MC rows
   function automatic logic [N-1:0] refresh(
      input logic [D-1:0]  r,
      input logic [MW-1:0] m
   );
      logic [N-1:0] f;
      f = '0;
      for (int rr = 0; rr < D; rr++) begin
         if (r[rr]) f = f ^ m[rr*N +: N];
      end
      return f;
   endfunction

   // one ACCUM step: fold the DIGIT bits selected by k into the accumulator
   always_comb begin
      acc_nxt = acc;
      for (int i = 0; i < N; i++) begin
         if (int'(k) == i / DIGIT) begin
            acc_nxt = acc_nxt ^ (AW'((p1_q[i] ? p2_q : '0)
                      ^ refresh(rnd_q[i*D +: D], MC)) << i);
         end
      end
   end

   // masked reduction; overflow and q are gated to zero outside REDUCE
   always_comb begin
      ov  = '0;
      q   = '0;
      red = '0;
      col = '0;
      if (state == REDUCE) begin
         ov = acc[AW-1:N];
         q  = rnd_q[N*D +: D];
      end
      v = {ov, q};
      for (int b = 0; b < 8; b++) begin
         col = '0;
         for (int j = 0; j < VW; j++) begin
            col[j] = B_ext[j*8 + b];
         end
         red[b] = ^(v & col);
      end
      res = {q, red} ^ acc[N-1:0];
   end

   // control FSM with registered handshake and result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out       <= '0;
         p1_q      <= '0;
         p2_q      <= '0;
         rnd_q     <= '0;
         acc       <= '0;
         k         <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  p1_q     <= p1;
                  p2_q     <= p2;
                  rnd_q    <= rand_vec;
                  acc      <= '0;
                  k        <= '0;
                  in_ready <= 1'b0;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               acc <= acc_nxt;
               if (k == KW'(STEPS - 1)) begin
                  k     <= '0;
                  state <= REDUCE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            REDUCE: begin
               out       <= res;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clm_digit_serial_multiplier.sv
// Bench for clm_digit_serial_multiplier: directed steps, scoreboard
// against a GF(2) reference model and GF(2^8) decoding.
module tb_clm_digit_serial_multiplier;

   localparam int D     = 2;
   localparam int N     = 10;
   localparam int STEPS = 10;
   localparam int RW    = (N + 1) * D;
   localparam int MW    = D * N;
   localparam int VW    = 7 + 2 * D;
   localparam int BW    = VW * 8;
   localparam int AW    = 2 * N - 1;
   localparam logic [MW-1:0] CODE_MC = {10'h236, 10'h11B};

   typedef struct {
      logic [N-1:0] word;
      logic         chk;
      logic [7:0]   data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic [N-1:0]  p1;
   logic [N-1:0]  p2;
   logic [RW-1:0] rand_vec;
   logic [MW-1:0] mc;
   logic [BW-1:0] b_ext;
   logic          in_ready;
   logic          out_valid;
   logic [N-1:0]  out;
   logic          in_ready_b;
   logic          out_valid_b;
   logic [N-1:0]  out_b;
   logic          in_ready_c;
   logic          out_valid_c;
   logic [N-1:0]  out_c;

   exp_t sb[$];
   exp_t e_mon;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   n_results = 0;
   int   cyc       = 0;

   clm_digit_serial_multiplier #(.D(D), .DIGIT(1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .p1(p1), .p2(p2), .rand_vec(rand_vec), .MC(mc), .B_ext(b_ext),
      .out_valid(out_valid), .out_ready(out_ready), .out(out)
   );

   clm_digit_serial_multiplier #(.D(D), .DIGIT(2)) u_dig2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .p1(p1), .p2(p2), .rand_vec(rand_vec), .MC(mc), .B_ext(b_ext),
      .out_valid(out_valid_b), .out_ready(1'b1), .out(out_b)
   );

   clm_digit_serial_multiplier #(.D(D), .DIGIT(5)) u_dig5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
      .p1(p1), .p2(p2), .rand_vec(rand_vec), .MC(mc), .B_ext(b_ext),
      .out_valid(out_valid_c), .out_ready(1'b1), .out(out_c)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                         input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] t;
      r = '0;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r = r ^ t;
         t = xtime(t);
      end
      return r;
   endfunction

   function automatic logic [7:0] decode(input logic [N-1:0] c);
      return c[7:0] ^ (c[8] ? 8'h1B : 8'h00) ^ (c[9] ? 8'h36 : 8'h00);
   endfunction

   function automatic logic [N-1:0] encode(input logic [7:0] a,
                                           input logic [1:0] r);
      return {2'b00, a} ^ (r[0] ? 10'h11B : 10'h000)
                        ^ (r[1] ? 10'h236 : 10'h000);
   endfunction

   // row j reduces x^(8+j) modulo the AES polynomial
   function automatic logic [BW-1:0] code_b();
      logic [BW-1:0] b;
      logic [7:0]    t;
      t = 8'h1B;
      b = '0;
      for (int j = 0; j < VW; j++) begin
         b[j*8 +: 8] = t;
         t = xtime(t);
      end
      return b;
   endfunction

   function automatic logic [N-1:0] model(
      input logic [N-1:0]  a,
      input logic [N-1:0]  b,
      input logic [RW-1:0] rv,
      input logic [MW-1:0] m,
      input logic [BW-1:0] bx
   );
      logic [AW-1:0] prod;
      logic [N-1:0]  f;
      logic [D-1:0]  r;
      logic [D-1:0]  qq;
      logic [VW-1:0] vv;
      logic [7:0]    low;
      prod = '0;
      for (int i = 0; i < N; i++) begin
         if (a[i]) prod = prod ^ (AW'(b) << i);
      end
      for (int i = 0; i < N; i++) begin
         r = rv[i*D +: D];
         f = '0;
         for (int rr = 0; rr < D; rr++) begin
            if (r[rr]) f = f ^ m[rr*N +: N];
         end
         prod = prod ^ (AW'(f) << i);
      end
      qq  = rv[N*D +: D];
      vv  = {prod[AW-1:N], qq};
      low = prod[7:0];
      for (int j = 0; j < VW; j++) begin
         if (vv[j]) low = low ^ bx[j*8 +: 8];
      end
      return {prod[N-1:8] ^ qq, low};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic gen_enc(output logic [N-1:0] a, output logic [N-1:0] b,
                          output logic [RW-1:0] rv, output exp_t e);
      logic [7:0] x;
      logic [7:0] y;
      x = 8'($urandom());
      y = 8'($urandom());
      a = encode(x, 2'($urandom()));
      b = encode(y, 2'($urandom()));
      for (int j = 0; j < RW; j++) rv[j] = 1'($urandom());
      e = '{word: model(a, b, rv, CODE_MC, code_b()), chk: 1'b1,
            data: gf_mul(x, y)};
   endtask

   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [RW-1:0] rv, input logic [MW-1:0] m,
                         input logic [BW-1:0] bx, input exp_t e);
      int w;
      p1 = a;
      p2 = b;
      rand_vec = rv;
      mc = m;
      b_ext = bx;
      in_valid = 1'b1;
      w = 0;
      while (in_ready !== 1'b1 && w < 40) begin
         tick();
         w++;
      end
      check("accept_wait", 32'(w < 40), 1);
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
      w = 0;
      while (sb.size() != 0 && w < 40) begin
         tick();
         w++;
      end
      check("result_wait", sb.size(), 0);
      sb.delete();
   endtask

   // result handshake seen at negedge completes on the next rising edge
   always @(negedge clk) begin
      if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         n_results++;
         check("result_expected", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            check("out_word", out, e_mon.word);
            if (e_mon.chk) check("decoded", decode(out), e_mon.data);
         end
      end
   end

   initial begin
      logic [N-1:0]  a;
      logic [N-1:0]  b;
      logic [RW-1:0] rv;
      logic [MW-1:0] m;
      logic [BW-1:0] bx;
      exp_t          e;
      int            la, lb, lc, w, base, prev, t;
      logic [N-1:0]  ob, oc;

      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      p1 = '0;
      p2 = '0;
      rand_vec = '0;
      mc = '0;
      b_ext = code_b();
      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      tick();

      // AES example on DIGIT 1, 2 and 5 with no masking
      p1 = 10'h057;
      p2 = 10'h083;
      rand_vec = '0;
      mc = '0;
      b_ext = code_b();
      in_valid = 1'b1;
      sb.push_back('{word: 10'h3EC, chk: 1'b1, data: 8'hC1});
      tick();
      in_valid = 1'b0;
      check("acc_in_ready_d1", in_ready, 0);
      check("acc_in_ready_d2", in_ready_b, 0);
      check("acc_in_ready_d5", in_ready_c, 0);
      la = 0;
      lb = 0;
      lc = 0;
      ob = '0;
      oc = '0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1 && la == 0) la = c;
         if (out_valid_b === 1'b1 && lb == 0) begin
            lb = c;
            ob = out_b;
         end
         if (out_valid_c === 1'b1 && lc == 0) begin
            lc = c;
            oc = out_c;
         end
      end
      #1;
      check("latency_d1", la, 11);
      check("latency_d2", lb, 6);
      check("latency_d5", lc, 3);
      check("out_d2", ob, 10'h3EC);
      check("out_d5", oc, 10'h3EC);
      check("aes_consumed", sb.size(), 0);

      // abort during ACCUM
      gen_enc(a, b, rv, e);
      p1 = a;
      p2 = b;
      rand_vec = rv;
      mc = CODE_MC;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      base = n_results;
      rst = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_out", out, 0);
      tick();
      rst = 1'b1;
      tick();
      tick();
      check("abort_no_result", n_results - base, 0);
      gen_enc(a, b, rv, e);
      run_op(a, b, rv, CODE_MC, code_b(), e);

      // 1000 vectors: odd ones are code operands, even ones fully random
      for (int n = 0; n < 1000; n++) begin
         if (n % 2 == 1) begin
            gen_enc(a, b, rv, e);
            run_op(a, b, rv, CODE_MC, code_b(), e);
         end else begin
            for (int j = 0; j < N; j++) a[j] = 1'($urandom());
            for (int j = 0; j < N; j++) b[j] = 1'($urandom());
            for (int j = 0; j < RW; j++) rv[j] = 1'($urandom());
            for (int j = 0; j < MW; j++) m[j] = 1'($urandom());
            for (int j = 0; j < BW; j++) bx[j] = 1'($urandom());
            e = '{word: model(a, b, rv, m, bx), chk: 1'b0, data: 8'h00};
            run_op(a, b, rv, m, bx, e);
         end
      end

      // output backpressure held for 20 cycles
      out_ready = 1'b0;
      gen_enc(a, b, rv, e);
      p1 = a;
      p2 = b;
      rand_vec = rv;
      mc = CODE_MC;
      b_ext = code_b();
      in_valid = 1'b1;
      w = 0;
      while (in_ready !== 1'b1 && w < 40) begin
         tick();
         w++;
      end
      check("stall_accept", 32'(w < 40), 1);
      sb.push_back(e);
      tick();
      in_valid = 1'b0;
      w = 0;
      while (out_valid !== 1'b1 && w < 40) begin
         tick();
         w++;
      end
      check("stall_done", out_valid, 1);
      for (int c = 0; c < 20; c++) begin
         in_valid = 1'(c % 2);
         p1 = N'($urandom());
         tick();
         check("stall_valid", out_valid, 1);
         check("stall_out", out, e.word);
         check("stall_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("release_out_valid", out_valid, 0);
      check("release_in_ready", in_ready, 1);
      check("release_out_hold", out, e.word);
      check("release_consumed", sb.size(), 0);

      // back-to-back with in_valid and out_ready held high
      base = n_results;
      prev = 0;
      in_valid = 1'b1;
      for (int n = 0; n < 6; n++) begin
         gen_enc(a, b, rv, e);
         p1 = a;
         p2 = b;
         rand_vec = rv;
         w = 0;
         while (in_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
         end
         check("b2b_accept", 32'(w < 40), 1);
         sb.push_back(e);
         t = cyc;
         if (n > 0) check("b2b_interval", t - prev, STEPS + 3);
         prev = t;
         tick();
      end
      in_valid = 1'b0;
      w = 0;
      while (sb.size() != 0 && w < 40) begin
         tick();
         w++;
      end
      tick();
      check("b2b_drained", sb.size(), 0);
      check("b2b_count", n_results - base, 6);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
